// File: rtl/mp_ring_buf.sv
// Multi-port ring buffer: WRITE compacted write lanes, READ prefix-pop read lanes, any DEPTH.
// Define RING_BUF_ERR_EN to build the sticky protocol-error flag; otherwise err is tied inactive.
module mp_ring_buf #(
  parameter int DATA  = 64,
  parameter int DEPTH = 16,
  parameter int READ  = 4,
  parameter int WRITE = 4,
  parameter bit ACT   = 1'b1,
  parameter int AFULL = DEPTH - WRITE,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int CNT   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       flush_,
  input  logic [WRITE-1:0]           we,
  input  logic [WRITE-1:0][DATA-1:0] wd,
  output logic [WRITE-1:0]           wv,
  output logic [WRITE-1:0][ADDR-1:0] widx,
  input  logic [READ-1:0]            re,
  output logic [READ-1:0][DATA-1:0]  rd,
  output logic [READ-1:0]            rv,
  output logic [READ-1:0][ADDR-1:0]  ridx,
  output logic [CNT-1:0]             count,
  output logic                       busy,
  output logic                       afull,
  output logic                       err
);

  localparam logic [CNT-1:0] DEPTH_C = CNT'(DEPTH);
  localparam logic [CNT-1:0] WRITE_C = CNT'(WRITE);
  localparam logic [CNT-1:0] AFULL_C = CNT'(AFULL);
  localparam logic [ADDR:0]  DEPTH_A = (ADDR+1)'(DEPTH);

  logic [DATA-1:0]           mem_q [DEPTH];
  logic [ADDR-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CNT-1:0]            count_q, count_d;
  logic [WRITE-1:0]          we_a, wv_a;
  logic [READ-1:0]           re_a, rv_a;
  logic [WRITE-1:0][CNT-1:0] wrank;
  logic [WRITE-1:0][ADDR-1:0] wslot;
  logic [READ-1:0][ADDR-1:0] rslot;
  logic [CNT-1:0]            free, nacc, npop;
  logic                      err_a;

  assign we_a = we ^ {WRITE{~ACT}};
  assign re_a = re ^ {READ{~ACT}};
  // Free space comes from start-of-cycle occupancy; same-cycle pops never make room.
  assign free = DEPTH_C - count_q;

  always_comb begin
    logic [CNT-1:0] run;
    run = '0;
    for (int i = 0; i < WRITE; i++) begin
      wrank[i] = run;
      run      = run + CNT'(we_a[i]);
    end
  end

  for (genvar gi = 0; gi < WRITE; gi++) begin : g_wr
    logic [ADDR:0] sum;
    assign sum       = {1'b0, head_q} + (ADDR+1)'(wrank[gi]);
    assign wslot[gi] = (sum >= DEPTH_A) ? ADDR'(sum - DEPTH_A) : sum[ADDR-1:0];
    assign wv_a[gi]  = we_a[gi] && (wrank[gi] < free) && flush_;
  end

  always_comb begin
    nacc = '0;
    for (int i = 0; i < WRITE; i++) nacc = nacc + CNT'(wv_a[i]);
  end

  for (genvar gi = 0; gi < READ; gi++) begin : g_rd
    logic [ADDR:0] sum;
    assign sum       = {1'b0, tail_q} + (ADDR+1)'(gi);
    assign rslot[gi] = (sum >= DEPTH_A) ? ADDR'(sum - DEPTH_A) : sum[ADDR-1:0];
    assign rv_a[gi]  = CNT'(gi) < count_q;
    assign rd[gi]    = mem_q[rslot[gi]];
  end

  // Pops stop at the first lane that is not both requested and valid.
  always_comb begin
    logic run;
    run  = 1'b1;
    npop = '0;
    for (int k = 0; k < READ; k++) begin
      run  = run & re_a[k] & rv_a[k];
      npop = npop + CNT'(run);
    end
  end

  always_comb begin
    logic [ADDR:0] hsum, tsum;
    hsum    = {1'b0, head_q} + (ADDR+1)'(nacc);
    tsum    = {1'b0, tail_q} + (ADDR+1)'(npop);
    head_d  = (hsum >= DEPTH_A) ? ADDR'(hsum - DEPTH_A) : hsum[ADDR-1:0];
    tail_d  = (tsum >= DEPTH_A) ? ADDR'(tsum - DEPTH_A) : tsum[ADDR-1:0];
    count_d = count_q + nacc - npop;
    if (!flush_) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WRITE; i++)
      if (wv_a[i]) mem_q[wslot[i]] <= wd[i];
  end

`ifdef RING_BUF_ERR_EN
  logic             err_q, err_d;
  logic [WRITE-1:0] wrej;
  for (genvar gi = 0; gi < WRITE; gi++) begin : g_err
    assign wrej[gi] = we_a[gi] && !(wrank[gi] < free);
  end
  assign err_d = err_q | (|wrej) | (|(re_a & ~rv_a));
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign err_a = err_q;
`else
  assign err_a = 1'b0;
`endif

  assign wv    = wv_a ^ {WRITE{~ACT}};
  assign rv    = rv_a ^ {READ{~ACT}};
  assign busy  = (free < WRITE_C) ^ ~ACT;
  assign afull = (count_q >= AFULL_C) ^ ~ACT;
  assign err   = err_a ^ ~ACT;
  assign widx  = wslot;
  assign ridx  = rslot;
  assign count = count_q;

endmodule

// File: doc/mp_ring_buf.md
MP_RING_BUF -- requirements
Module: mp_ring_buf

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA, 64, entry width in bits
- DEPTH, 16, entry count; any value >= max(READ, WRITE), not restricted to powers of two
- READ, 4, read lanes
- WRITE, 4, write lanes
- ACT, High, active level of we/re/wv/rv/busy/afull/err
- AFULL, DEPTH-WRITE, occupancy at or above which afull asserts
- ADDR, $clog2(DEPTH), derived constant
- CNT, $clog2(DEPTH+1), derived constant
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; one clock, all state on its rising edge
- reset_  in  1  asynchronous, active-low reset
- flush_  in  1  synchronous clear, active-low
- we  in  WRITE  write request per lane
- wd  in  WRITE x DATA  write data per lane
- wv  out  WRITE  write lane accepted this cycle
- widx  out  WRITE x ADDR  slot assigned to each lane
- re  in  READ  read request per lane
- rd  out  READ x DATA  data at tail+k
- rv  out  READ  entry tail+k valid
- ridx  out  READ x ADDR  slot tail+k
- count  out  CNT  current occupancy
- busy  out  1  free slots < WRITE
- afull  out  1  count >= AFULL
- err  out  1  sticky protocol-error flag

Function
REQ-003 Enabled write lanes SHALL be compacted: the n-th enabled lane (rank n, from lane 0) targets slot (head+n) mod DEPTH.
REQ-004 A write lane SHALL be accepted (wv asserted, same cycle, combinational) iff enabled and rank < DEPTH-count; lanes not accepted SHALL be dropped.
REQ-005 Free space SHALL be computed from count at the start of the cycle; same-cycle reads SHALL NOT free space for writes.
REQ-006 rd[k]/rv[k]/ridx[k] SHALL present slot (tail+k) mod DEPTH combinationally; rv[k] asserted iff k < count.
REQ-007 Reads SHALL be a prefix: the number popped SHALL equal the count of consecutive enabled lanes from lane 0 with rv asserted; re lanes beyond the first gap or beyond rv SHALL be ignored.
REQ-008 On each edge: head += accepted writes, tail += popped reads (both mod DEPTH via compare-and-subtract, no power-of-two wrap); count += accepted writes - popped.
REQ-009 Written data SHALL become readable the cycle after acceptance; no write-to-read bypass.
REQ-010 Full (count==DEPTH): all wv deasserted, busy asserted; reads proceed normally.
REQ-011 Empty (count==0): all rv deasserted; re ignored.
REQ-012 Simultaneous pop and write with count==DEPTH SHALL pop only; with count==0 SHALL write only.
REQ-013 flush_ low SHALL set head, tail and count to 0 at the next edge, overriding same-cycle reads and writes; wv SHALL be deasserted while flush_ is low; flush_ SHALL NOT clear err.
REQ-014 Popped slot data SHALL NOT be cleared; validity SHALL derive from count only.

Reset
REQ-015 reset_ low SHALL asynchronously set head=0, tail=0, count=0 and err deasserted; outputs then read rv=0, wv=0, busy=0, afull=0 (AFULL>0).
REQ-016 Deassertion of reset_ SHALL take effect on the first clk edge with reset_ high; data storage need not be reset.

Configuration
REQ-017 With macro RING_BUF_ERR_EN defined, err SHALL set on the next edge when any enabled write lane is rejected or any enabled read lane has rv deasserted, and stays set until reset_.
REQ-018 Without RING_BUF_ERR_EN, err SHALL be tied to inactive and no error logic SHALL be synthesised.

Verification
(DATA=16, DEPTH=6, READ=WRITE=4, ACT=High, AFULL=2)
REQ-019 After reset, we=4'b1010, wd lanes 1/3 = 0xA1/0xA3 -> wv=4'b1010, widx lanes 1/3 = 0/1; next cycle rv=4'b0011, rd[0]=0xA1, rd[1]=0xA3, count=2, afull=1.
REQ-020 count=5, we=4'b1111 -> wv=4'b0001, count=6, busy=1, next-cycle wv=0; with RING_BUF_ERR_EN err=1 next cycle.
REQ-021 head=tail=4, count=0, write 4 entries then pop 4 -> widx=4,5,0,1; ridx same order; head=tail=2, count=0.
REQ-022 count=6, we=4'b0011, re=4'b0011 -> wv=0, 2 pops, count=4.
REQ-023 count=3, re=4'b1101 -> only lane 0 pops, count=2.
REQ-024 flush_ low with we=4'b1111, re=4'b0001, count=3 -> count=0, rv=0, wv=0; asynchronous reset_ mid-write -> count=0 immediately, err cleared.
